// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: flag bit positions and
// the occupancy encoding of the writeback buffer.
package alu_writeback_pkg;

   localparam int FLAG_W = 4;
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } fifo_cnt_e;

endpackage

// File: rtl/alu_writeback_fifo2.sv
// Two-entry valid/ready FIFO; head is always driven straight from storage,
// so there is no combinational path from push to the output side.
//
// state     | meaning
// CNT_EMPTY | no entries, valid_o low
// CNT_ONE   | one entry at rd_ptr
// CNT_FULL  | both entries used, full_o high blocks upstream
module wb_fifo2
   import alu_writeback_pkg::*;
#(
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   output logic         full_o,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   fifo_cnt_e    cnt_q, cnt_d;
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, rd_ptr_q;
   logic         push_ok, pop_ok;

   assign push_ok = push_i & (cnt_q != CNT_FULL);
   assign pop_ok  = ready_i & (cnt_q != CNT_EMPTY);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) cnt_q <= CNT_EMPTY;
      else         cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      case (cnt_q)
         CNT_EMPTY: if (push_ok) cnt_d = CNT_ONE;
         CNT_ONE: begin
            if (push_ok && !pop_ok)      cnt_d = CNT_FULL;
            else if (pop_ok && !push_ok) cnt_d = CNT_EMPTY;
         end
         CNT_FULL:  if (pop_ok) cnt_d = CNT_ONE;
         default:   cnt_d = CNT_EMPTY;
      endcase
   end

   // Storage is cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign full_o  = (cnt_q == CNT_FULL);
   assign valid_o = (cnt_q != CNT_EMPTY);
   assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: derives and holds the C/Z/N/V flags under a per-op
// mask and queues register-file writes in a two-entry buffer.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int N        = 16,
   parameter int REG_BITS = 3
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                inValid,
   output logic                inReady,
   input  logic [N:0]          result,
   input  logic                operand1Msb,
   input  logic                operand2Msb,
   input  logic                isSub,
   input  logic [FLAG_W-1:0]   flagMask,
   input  logic [REG_BITS-1:0] destReg,
   input  logic                writeEn,
   output logic                carryFlag,
   output logic [FLAG_W-1:0]   flags,
   output logic                wbValid,
   input  logic                wbReady,
   output logic [REG_BITS-1:0] wbAddr,
   output logic [N-1:0]        wbData
);

   logic [FLAG_W-1:0]     flags_q, flags_d, new_flags;
   logic                  acc, full, res_msb;
   logic [REG_BITS+N-1:0] head;

   assign acc     = inValid & inReady;
   assign res_msb = result[N-1];

   // V uses the add or subtract overflow rule; the decoder masks it for other ops.
   always_comb begin
      new_flags         = '0;
      new_flags[FLAG_C] = result[N];
      new_flags[FLAG_Z] = (result[N-1:0] == '0);
      new_flags[FLAG_N] = res_msb;
      new_flags[FLAG_V] = isSub ? ((operand1Msb != operand2Msb) & (res_msb != operand1Msb))
                                : ((operand1Msb == operand2Msb) & (res_msb != operand1Msb));
      flags_d = flags_q;
      if (acc) flags_d = (flagMask & new_flags) | (~flagMask & flags_q);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) flags_q <= '0;
      else         flags_q <= flags_d;
   end

   assign flags     = flags_q;
   assign carryFlag = flags_q[FLAG_C];

   wb_fifo2 #(.W(REG_BITS + N)) u_fifo (
      .clk         (clk),
      .resetN      (resetN),
      .push_i      (acc & writeEn),
      .push_data_i ({destReg, result[N-1:0]}),
      .full_o      (full),
      .valid_o     (wbValid),
      .ready_i     (wbReady),
      .data_o      (head)
   );

   assign inReady = ~full;
   assign wbAddr  = head[REG_BITS+N-1:N];
   assign wbData  = head[N-1:0];

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Pipeline stage directly downstream of the ALU.
- Captures the ALU's (N+1)-bit result each issue and derives the status flags C/Z/N/V under a per-instruction update mask.
- Holds the architectural flag register; its carry output feeds the ALU carry input.
- Queues register-file writes in a 2-entry buffer with valid/ready back-pressure toward the register file.

Parameters:
- N, 16, data width; ALU result is N+1 bits.
- REG_BITS, 3, register-file address width.

Ports:
- clk  input  1  system clock, rising edge
- resetN  input  1  asynchronous active-low reset
- inValid  input  1  ALU result valid this cycle
- inReady  output  1  stage can accept (buffer not full)
- result  input  N+1  ALU result; bit N = carry/borrow out
- operand1Msb  input  1  operand1[N-1] of this operation
- operand2Msb  input  1  operand2[N-1] of this operation
- isSub  input  1  operation was SUB/SBC (selects overflow rule)
- flagMask  input  4  per-flag update enable {C,Z,N,V}
- destReg  input  REG_BITS  destination register
- writeEn  input  1  result is written to a register (0 = flags-only, e.g. compare)
- carryFlag  output  1  registered C, to ALU carry input
- flags  output  4  registered {C,Z,N,V}
- wbValid  output  1  buffer head valid
- wbReady  input  1  register file accepts head
- wbAddr  output  REG_BITS  head destination
- wbData  output  N  head data

Behaviour:
- Reset (resetN low, asynchronous):
  - flags=0, carryFlag=0.
  - Buffer empty, so wbValid=0, wbAddr=0, wbData=0 (storage cleared), inReady=1.
  - Reset mid-transfer discards all buffered entries; no partial write is ever presented after reset.
- Accept:
  - acc = inValid & inReady.
  - If inValid and !inReady, the input is ignored completely: no flag change, no enqueue. Upstream holds its inputs.
- Flag derivation (combinational from inputs, registered on acc):
  - C = result[N].
  - Z = (result[N-1:0]==0).
  - Nf = result[N-1].
  - V: add: (op1Msb==op2Msb) & (result[N-1]!=op1Msb); sub: (op1Msb!=op2Msb) & (result[N-1]!=op1Msb).
  - Logic/shift/load ops set V through the same rule; masking out V for those ops is the decoder's responsibility via flagMask.
- Flag update:
  - On the acc edge, each flag bit with flagMask bit set takes its new value; the others hold.
  - Latency 1: carryFlag reflects an ADD in the cycle after acceptance, so a back-to-back ADC sees it.
  - Flags update on acc regardless of writeEn and regardless of buffer occupancy downstream.
- Buffer: 2-entry FIFO of {destReg, result[N-1:0]}.
  - Count state EMPTY(0), ONE(1), FULL(2).
  - push = acc & writeEn.
  - pop = wbValid & wbReady.
  - Transitions:
    - EMPTY: push→ONE.
    - ONE: push&!pop→FULL; pop&!push→EMPTY; push&pop→ONE.
    - FULL: pop→ONE. Push cannot occur in FULL because inReady=0.
  - Simultaneous push and pop in ONE: the new entry becomes head next cycle; no bubble.
  - Simultaneous push and pop in EMPTY: only the push takes effect; wbValid rises next cycle, since there is no combinational flow-through.
  - inReady = (count!=2), combinational from registered count only; no dependency on wbReady.
  - wbValid = (count!=0).
  - wbAddr/wbData are driven from the head register and are stable while wbValid & !wbReady.
- Pointers:
  - Read and write pointers are 1 bit each and wrap naturally at 2.
  - Count is derived from the pointers plus a full bit, or kept explicitly; either way it is fully consistent at all times.

Decomposition:
- Shared package/header: flag bit indices (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0) and the 4-bit mask width, reused by the decoder and the branch-condition logic.
- One natural sub-module: wb_fifo2, a parameterised 2-entry valid/ready FIFO of width REG_BITS+N.
- Flag computation stays in alu_writeback.

Test Plan:
- result=0x08000 from add with op1Msb=0, op2Msb=0, mask=0xF, writeEn=1 → next cycle flags={C0,Z0,N1,V1}; wbValid=1, wbData=0x8000.
- SUB 5-5: result=0x00000, isSub=1, mask=0xF → flags={0,1,0,0}. Then result=0x1FFFF with mask=0x8 → only C→1; Z stays 1.
- wbReady=0 with three consecutive writes of 0x0001/0x0002/0x0003 → after two accepts inReady=0. The third is held, flags unchanged for it; wbData stays 0x0001. Raise wbReady → drains 1,2,3 in order, one per cycle.
- Count ONE with push and wbReady=1 in the same cycle → count stays ONE, head advances to new data, inReady stays 1.
- writeEn=0 compare, result=0x10000, mask=0x8 → carryFlag=1 next cycle, wbValid unchanged.
- Buffer FULL, assert resetN=0 asynchronously mid-cycle → wbValid, flags and carryFlag drop immediately; inReady=1; after release, no stale write appears.
